// File: rtl/riscv_batch_runner.sv
// riscv_batch_runner: sequences a batch of RISC-V test images through a CPU.
// For each test it asks the loader for the image and holds the CPU in reset.
// It then lets the CPU run until it fetches the halt word or hits the cycle
// limit, and classifies the result from a0 into the per-test result masks.
module riscv_batch_runner #(
    parameter int          NUM_TESTS  = 4,
    parameter int          MAX_CYCLES = 10000,
    parameter int          RST_CYCLES = 1,
    parameter logic [31:0] HALT_WORD  = 32'hdead10cc,
    parameter logic [31:0] PASS_MAGIC = 32'h00c0ffee,
    parameter logic [31:0] FAIL_MAGIC = 32'hdeaddead,
    localparam int         CYC_W      = $clog2(MAX_CYCLES + 1),
    localparam int         ID_W       = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic                 load_req,
    input  logic                 load_done,
    output logic [ID_W-1:0]      test_id,
    output logic                 cpu_reset,
    input  logic [31:0]          imemdataout,
    input  logic [31:0]          a0_value,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_TESTS-1:0] pass_mask,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [NUM_TESTS-1:0] timeout_mask,
    output logic [NUM_TESTS-1:0] unknown_mask,
    output logic [CYC_W-1:0]     cycles_last
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RST   = 3'd2,
        RUN   = 3'd3,
        CHECK = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Reset-hold counter only needs to reach RST_CYCLES-1.
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [RC_W-1:0]  RST_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_MAX   = CYC_W'(MAX_CYCLES);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_TESTS - 1);

    state_t                 state_reg, state_next;
    logic [ID_W-1:0]        test_id_reg, test_id_next;
    logic [RC_W-1:0]        rcnt_reg, rcnt_next;
    logic [CYC_W-1:0]       cyc_reg, cyc_next;
    logic                   timeout_reg, timeout_next;
    logic [NUM_TESTS-1:0]   pass_reg, pass_next;
    logic [NUM_TESTS-1:0]   fail_reg, fail_next;
    logic [NUM_TESTS-1:0]   tmo_reg, tmo_next;
    logic [NUM_TESTS-1:0]   unk_reg, unk_next;
    logic [CYC_W-1:0]       cycles_last_reg, cycles_last_next;

    // One-hot select of the current test, used to set its result bits.
    logic [NUM_TESTS-1:0]   test_sel;
    logic                   busy_state;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TESTS; gi = gi + 1) begin : g_sel
            assign test_sel[gi] = (test_id_reg == ID_W'(gi));
        end
    endgenerate

    assign busy_state = (state_reg == LOAD) || (state_reg == RST) ||
                        (state_reg == RUN)  || (state_reg == CHECK) ||
                        (state_reg == NEXT);

    // Outputs decode from registered state only: no input reaches an output.
    assign load_req     = (state_reg == LOAD);
    assign cpu_reset    = (state_reg != RUN);
    assign busy         = busy_state;
    assign done         = (state_reg == DONE);
    assign test_id      = test_id_reg;
    assign pass_mask    = pass_reg;
    assign fail_mask    = fail_reg;
    assign timeout_mask = tmo_reg;
    assign unknown_mask = unk_reg;
    assign cycles_last  = cycles_last_reg;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            test_id_reg     <= '0;
            rcnt_reg        <= '0;
            cyc_reg         <= '0;
            timeout_reg     <= 1'b0;
            pass_reg        <= '0;
            fail_reg        <= '0;
            tmo_reg         <= '0;
            unk_reg         <= '0;
            cycles_last_reg <= '0;
        end else begin
            state_reg       <= state_next;
            test_id_reg     <= test_id_next;
            rcnt_reg        <= rcnt_next;
            cyc_reg         <= cyc_next;
            timeout_reg     <= timeout_next;
            pass_reg        <= pass_next;
            fail_reg        <= fail_next;
            tmo_reg         <= tmo_next;
            unk_reg         <= unk_next;
            cycles_last_reg <= cycles_last_next;
        end
    end

    // Next-state and datapath updates; abort from a busy state wins over all else.
    always_comb begin
        state_next       = state_reg;
        test_id_next     = test_id_reg;
        rcnt_next        = rcnt_reg;
        cyc_next         = cyc_reg;
        timeout_next     = timeout_reg;
        pass_next        = pass_reg;
        fail_next        = fail_reg;
        tmo_next         = tmo_reg;
        unk_next         = unk_reg;
        cycles_last_next = cycles_last_reg;

        if (abort && busy_state) begin
            // Results gathered so far are kept; only the sequencing stops.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_next       = LOAD;
                        test_id_next     = '0;
                        pass_next        = '0;
                        fail_next        = '0;
                        tmo_next         = '0;
                        unk_next         = '0;
                        cycles_last_next = '0;
                    end
                end
                LOAD: begin
                    if (load_done) begin
                        state_next = RST;
                        rcnt_next  = '0;
                    end
                end
                RST: begin
                    if (rcnt_reg == RST_LAST) begin
                        state_next   = RUN;
                        cyc_next     = '0;
                        timeout_next = 1'b0;
                    end else begin
                        rcnt_next = rcnt_reg + RC_W'(1);
                    end
                end
                RUN: begin
                    // Halt is checked first so a halt on the last allowed
                    // cycle still counts as a normal finish.
                    if (imemdataout == HALT_WORD) begin
                        state_next = CHECK;
                    end else if (cyc_reg == CYC_LIMIT) begin
                        state_next   = CHECK;
                        timeout_next = 1'b1;
                        cyc_next     = CYC_MAX;
                    end else begin
                        cyc_next = cyc_reg + CYC_W'(1);
                    end
                end
                CHECK: begin
                    cycles_last_next = cyc_reg;
                    if (timeout_reg) begin
                        tmo_next = tmo_reg | test_sel;
                    end else if (a0_value == PASS_MAGIC) begin
                        pass_next = pass_reg | test_sel;
                    end else if (a0_value == FAIL_MAGIC) begin
                        fail_next = fail_reg | test_sel;
                    end else begin
                        // Unrecognised a0 is a failure that is also flagged
                        // so it can be told apart from a reported failure.
                        fail_next = fail_reg | test_sel;
                        unk_next  = unk_reg | test_sel;
                    end
                    state_next = NEXT;
                end
                NEXT: begin
                    if (test_id_reg == ID_LAST) begin
                        state_next = DONE;
                    end else begin
                        test_id_next = test_id_reg + ID_W'(1);
                        state_next   = LOAD;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_batch_runner.sv
// Bench for riscv_batch_runner: a loader/CPU environment reacts to the DUT.
// A duration-based model lays out the expected per-cycle outputs of each batch.
// A compare process checks every queued cycle; literal checks pin the model.
module tb_riscv_batch_runner;

    localparam int NT    = 3;
    localparam int MC    = 16;
    localparam int RC    = 1;
    localparam int CYC_W = $clog2(MC + 1);
    localparam int ID_W  = (NT > 1) ? $clog2(NT) : 1;

    localparam logic [31:0] HALT_W = 32'hdead10cc;
    localparam logic [31:0] PASS_W = 32'h00c0ffee;
    localparam logic [31:0] BAD_W  = 32'hdeaddead;
    localparam logic [31:0] NOP_W  = 32'h00000013;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic              load_req;
    logic              load_done;
    logic [ID_W-1:0]   test_id;
    logic              cpu_reset;
    logic [31:0]       imemdataout;
    logic [31:0]       a0_value;
    logic              busy;
    logic              done;
    logic [NT-1:0]     pass_mask;
    logic [NT-1:0]     fail_mask;
    logic [NT-1:0]     timeout_mask;
    logic [NT-1:0]     unknown_mask;
    logic [CYC_W-1:0]  cycles_last;

    riscv_batch_runner #(
        .NUM_TESTS  (NT),
        .MAX_CYCLES (MC),
        .RST_CYCLES (RC),
        .HALT_WORD  (HALT_W),
        .PASS_MAGIC (PASS_W),
        .FAIL_MAGIC (BAD_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .load_req     (load_req),
        .load_done    (load_done),
        .test_id      (test_id),
        .cpu_reset    (cpu_reset),
        .imemdataout  (imemdataout),
        .a0_value     (a0_value),
        .busy         (busy),
        .done         (done),
        .pass_mask    (pass_mask),
        .fail_mask    (fail_mask),
        .timeout_mask (timeout_mask),
        .unknown_mask (unknown_mask),
        .cycles_last  (cycles_last)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic             lr;
        logic             cr;
        logic             bz;
        logic             dn;
        logic [ID_W-1:0]  id;
        logic [NT-1:0]    pm;
        logic [NT-1:0]    fm;
        logic [NT-1:0]    tm;
        logic [NT-1:0]    um;
        logic [CYC_W-1:0] cl;
    } exp_t;

    exp_t exp_q[$];
    exp_t batch_q[$];
    exp_t cur_steady;
    exp_t e_cur;
    exp_t a_cur;

    int n_cmp = 0;
    int n_bad = 0;
    int trace_cyc = 0;
    int batch_no = 0;

    // Per-test environment configuration: RUN cycle of the halt (-1 = never) and a0.
    int          halt_at[NT];
    logic [31:0] a0_cfg[NT];

    // Model state: results visible on the outputs at the cycle being laid out.
    logic [NT-1:0]    m_p, m_f, m_t, m_u;
    logic [CYC_W-1:0] m_cl;
    logic [ID_W-1:0]  m_id;

    function automatic exp_t mk(input logic lr, input logic cr, input logic bz, input logic dn);
        exp_t e;
        e.lr = lr; e.cr = cr; e.bz = bz; e.dn = dn;
        e.id = m_id; e.pm = m_p; e.fm = m_f; e.tm = m_t; e.um = m_u; e.cl = m_cl;
        return e;
    endfunction

    // Cycles a test occupies from first LOAD cycle through NEXT.
    function automatic int test_len(input int t);
        int n;
        n = (halt_at[t] >= 0 && halt_at[t] < MC) ? halt_at[t] + 1 : MC;
        return 3 + RC + n + 2;
    endfunction

    // Lay out one full batch: LOAD 3 cycles (loader answers on its 3rd cycle),
    // RST, RUN until halt or limit, CHECK, NEXT; then a DONE tail.
    task automatic gen_batch();
        batch_q.delete();
        m_p = '0; m_f = '0; m_t = '0; m_u = '0; m_cl = '0; m_id = '0;
        for (int t = 0; t < NT; t++) begin
            int n;
            int c;
            bit to;
            m_id = ID_W'(t);
            repeat (3) batch_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0));
            repeat (RC) batch_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
            if (halt_at[t] >= 0 && halt_at[t] < MC) begin
                n = halt_at[t] + 1; c = halt_at[t]; to = 1'b0;
            end else begin
                n = MC; c = MC; to = 1'b1;
            end
            repeat (n) batch_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
            batch_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
            m_cl = CYC_W'(c);
            if (to) m_t[t] = 1'b1;
            else if (a0_cfg[t] == PASS_W) m_p[t] = 1'b1;
            else if (a0_cfg[t] == BAD_W) m_f[t] = 1'b1;
            else begin m_f[t] = 1'b1; m_u[t] = 1'b1; end
            batch_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
        end
        repeat (3) batch_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1));
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Run one batch. abort_c / rst_c: cycle (1 = first LOAD cycle) in which
    // abort or async reset is raised, 0 = none. restart_c: extra start pulse.
    task automatic run_batch(input int abort_c, input int rst_c, input int restart_c);
        exp_t tailv;
        int total;
        gen_batch();
        if (abort_c > 0) begin
            while (batch_q.size() > abort_c) void'(batch_q.pop_back());
            tailv = batch_q[abort_c-1];
            tailv.lr = 1'b0; tailv.cr = 1'b1; tailv.bz = 1'b0; tailv.dn = 1'b0;
            repeat (4) batch_q.push_back(tailv);
        end
        if (rst_c > 0) begin
            while (batch_q.size() > rst_c - 1) void'(batch_q.pop_back());
            tailv = '0;
            tailv.cr = 1'b1;
            repeat (4) batch_q.push_back(tailv);
        end
        total = batch_q.size();
        @(posedge clock); #2;
        exp_q.push_back(cur_steady);
        foreach (batch_q[i]) exp_q.push_back(batch_q[i]);
        start = 1'b1;
        for (int k = 1; k <= total; k++) begin
            @(posedge clock); #2;
            start = (k == restart_c);
            abort = (k == abort_c);
            if (k == rst_c) begin
                reset = 1'b1;
                #1;
                check("async_rst_load_req", 32'(load_req), 32'd0);
                check("async_rst_cpu_reset", 32'(cpu_reset), 32'd1);
                check("async_rst_pass_mask", 32'(pass_mask), 32'd0);
                check("async_rst_busy", 32'(busy), 32'd0);
            end
            if (rst_c > 0 && k == rst_c + 1) reset = 1'b0;
        end
        cur_steady = batch_q[total-1];
        @(negedge clock); #1;
        check("trace_drained", 32'(exp_q.size()), 32'd0);
        batch_no++;
        $display("batch %0d: pass=%b fail=%b timeout=%b unknown=%b cycles_last=%0d done=%b",
                 batch_no, pass_mask, fail_mask, timeout_mask, unknown_mask, cycles_last, done);
    endtask

    // Environment: loader answers after two waiting cycles; the CPU fetches the
    // halt word on the configured RUN cycle and presents the test's a0.
    int   lcnt = 0;
    int   rcnt = 0;
    int   env_test = -1;
    int   last_run = 0;
    logic prev_lr = 1'b0;

    always @(posedge clock) begin
        #2;
        if (!busy) env_test = -1;
        else if (load_req && !prev_lr) env_test++;
        prev_lr = load_req;
        if (load_req) begin
            load_done = (lcnt >= 2);
            lcnt++;
        end else begin
            lcnt = 0;
            load_done = 1'b0;
        end
        if (!cpu_reset) begin
            imemdataout = (env_test >= 0 && env_test < NT && rcnt == halt_at[env_test]) ? HALT_W : NOP_W;
            rcnt++;
        end else begin
            if (rcnt > 0) last_run = rcnt;
            rcnt = 0;
            imemdataout = NOP_W;
        end
        a0_value = (env_test >= 0 && env_test < NT) ? a0_cfg[env_test] : 32'h0;
    end

    // Single compare process: every queued cycle is checked against the DUT.
    always @(negedge clock) begin
        trace_cyc++;
        if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            a_cur = {load_req, cpu_reset, busy, done, test_id, pass_mask, fail_mask,
                     timeout_mask, unknown_mask, cycles_last};
            n_cmp++;
            if (a_cur !== e_cur) begin
                n_bad++;
                $display("FAIL trace@%0d got lr=%b cr=%b busy=%b done=%b id=%0d p=%b f=%b t=%b u=%b cl=%0d, want lr=%b cr=%b busy=%b done=%b id=%0d p=%b f=%b t=%b u=%b cl=%0d",
                         trace_cyc, a_cur.lr, a_cur.cr, a_cur.bz, a_cur.dn, a_cur.id, a_cur.pm,
                         a_cur.fm, a_cur.tm, a_cur.um, a_cur.cl, e_cur.lr, e_cur.cr, e_cur.bz,
                         e_cur.dn, e_cur.id, e_cur.pm, e_cur.fm, e_cur.tm, e_cur.um, e_cur.cl);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; load_done = 1'b0;
        imemdataout = NOP_W; a0_value = 32'h0;
        halt_at = '{5, 5, 5};
        a0_cfg  = '{PASS_W, PASS_W, PASS_W};
        #3;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_load_req", 32'(load_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_test_id", 32'(test_id), 32'd0);
        check("rst_masks", 32'({pass_mask, fail_mask, timeout_mask, unknown_mask}), 32'd0);
        check("rst_cycles_last", 32'(cycles_last), 32'd0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        cur_steady = '0;
        cur_steady.cr = 1'b1;

        // All pass, halt on RUN cycle 5.
        run_batch(0, 0, 0);
        check("allpass_pass", 32'(pass_mask), 32'b111);
        check("allpass_other", 32'({fail_mask, timeout_mask, unknown_mask}), 32'd0);
        check("allpass_cycles", 32'(cycles_last), 32'd5);
        check("allpass_done", 32'(done), 32'd1);

        // Test 1 reports failure.
        a0_cfg[1] = BAD_W;
        run_batch(0, 0, 0);
        check("fail_pass", 32'(pass_mask), 32'b101);
        check("fail_fail", 32'(fail_mask), 32'b010);
        check("fail_unknown", 32'(unknown_mask), 32'b000);

        // Test 2 never halts: 16 RUN cycles then timeout.
        a0_cfg  = '{PASS_W, PASS_W, PASS_W};
        halt_at = '{3, 7, -1};
        run_batch(0, 0, 0);
        check("tmo_mask", 32'(timeout_mask), 32'b100);
        check("tmo_pass", 32'(pass_mask), 32'b011);
        check("tmo_cycles", 32'(cycles_last), 32'd16);
        check("tmo_run_len", 32'(last_run), 32'd16);

        // Halt on the last allowed cycle is a pass.
        halt_at[2] = 15;
        run_batch(0, 0, 0);
        check("edge_pass", 32'(pass_mask), 32'b111);
        check("edge_tmo", 32'(timeout_mask), 32'b000);
        check("edge_cycles", 32'(cycles_last), 32'd15);

        // Unknown a0 on test 0.
        halt_at = '{5, 5, 5};
        a0_cfg[0] = 32'h12345678;
        run_batch(0, 0, 0);
        check("unk_fail", 32'(fail_mask), 32'b001);
        check("unk_unknown", 32'(unknown_mask), 32'b001);
        check("unk_pass", 32'(pass_mask), 32'b110);

        // Abort in RUN cycle 2 of test 1; a start during LOAD is ignored.
        a0_cfg  = '{PASS_W, PASS_W, PASS_W};
        halt_at = '{4, 6, 5};
        run_batch(test_len(0) + 3 + RC + 3, 0, 2);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        check("abort_load_req", 32'(load_req), 32'd0);
        check("abort_pass", 32'(pass_mask), 32'b001);
        check("abort_test_id", 32'(test_id), 32'd1);

        // Async reset during LOAD of test 1 discards results.
        run_batch(0, test_len(0) + 2, 0);
        check("rst_mid_masks", 32'({pass_mask, fail_mask, timeout_mask, unknown_mask}), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);

        // A fresh start after reset runs normally.
        run_batch(0, 0, 0);
        check("recover_pass", 32'(pass_mask), 32'b111);
        check("recover_cycles", 32'(cycles_last), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
